// File: rtl/alu_pkg.sv
// Shared encodings for the ALU initiator: op selects, sequencer states, default width.
package alu_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [2:0] {
    SelAnd = 3'd0,
    SelOr  = 3'd1,
    SelXor = 3'd2,
    SelNor = 3'd3,
    SelLt  = 3'd4,
    SelAdd = 3'd5,
    SelSub = 3'd6,
    SelMod = 3'd7
  } alu_sel_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSettle = 3'd1,
    StStart  = 3'd2,
    StWait   = 3'd3,
    StResp   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_timeout_counter.sv
// Cycle counter for the mod wait: cleared on start, counts while enabled, flags the last cycle.
module alu_timeout_counter #(
  parameter int unsigned Limit = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Limit) + 1;

  logic [CntW-1:0] count_q, count_d;

  // Clear has priority so a fresh op always starts counting from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == CntW'(Limit - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the 32-bit ALU: takes one op over valid/ready, drives the ALU, returns the result.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH          = DefaultWidth,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_sel,
  input  logic             req_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_cin,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c_out,
  input  logic             alu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_c_out,
  output logic             rsp_err
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             alu_cin_q, alu_cin_d;
  logic             alu_start_q, alu_start_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_c_out_q, rsp_c_out_d;
  logic             rsp_err_q, rsp_err_d;

  logic cnt_clear, cnt_enable, cnt_expired;

  assign cnt_clear  = (state_q == StStart);
  assign cnt_enable = (state_q == StWait);

  alu_timeout_counter #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clear_i  (cnt_clear),
    .enable_i (cnt_enable),
    .expired_o(cnt_expired)
  );

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    alu_cin_d    = alu_cin_q;
    alu_start_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_c_out_d  = rsp_c_out_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_sel_d = req_sel;
          alu_cin_d = req_cin;
          if (req_sel == SelMod) begin
            state_d     = StStart;
            alu_start_d = 1'b1;
          end else begin
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        rsp_result_d = alu_result;
        rsp_c_out_d  = (alu_sel_q == SelAdd) ? alu_c_out : 1'b0;
        rsp_err_d    = 1'b0;
        state_d      = StResp;
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        // Done is checked first so a completion on the final allowed cycle still succeeds.
        if (alu_done) begin
          rsp_result_d = alu_result;
          rsp_c_out_d  = 1'b0;
          rsp_err_d    = 1'b0;
          state_d      = StResp;
        end else if (cnt_expired) begin
          rsp_result_d = '0;
          rsp_c_out_d  = 1'b0;
          rsp_err_d    = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        // Valid rises one cycle after entering; only a presented response can handshake.
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    req_ready_d = (state_d == StIdle);
  end

  // State and registered outputs; reset drops any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_cin_q    <= 1'b0;
      alu_start_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_c_out_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      alu_cin_q    <= alu_cin_d;
      alu_start_q  <= alu_start_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_c_out_q  <= rsp_c_out_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign alu_cin    = alu_cin_q;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_c_out  = rsp_c_out_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU and reference model.
module tb_alu_op_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0, req_b = '0;
  logic [2:0]    req_sel = '0;
  logic          req_cin = 1'b0;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_sel;
  logic          alu_cin, alu_start;
  logic [W-1:0]  alu_result;
  logic          alu_c_out, alu_done;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_result;
  logic          rsp_c_out, rsp_err;

  alu_op_sequencer #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .req_cin   (req_cin),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_cin   (alu_cin),
    .alu_start (alu_start),
    .alu_result(alu_result),
    .alu_c_out (alu_c_out),
    .alu_done  (alu_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_c_out (rsp_c_out),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural ALU ----------------
  int unsigned mod_lat = 1;
  logic        stale_done = 1'b0;
  int unsigned mcnt;
  logic [32:0] alu_sum;

  always @(posedge clk or negedge reset) begin
    if (!reset) mcnt <= 0;
    else if (alu_start) mcnt <= 1;
    else if (mcnt != 0 && mcnt < 1000) mcnt <= mcnt + 1;
  end

  assign alu_done = (mcnt == mod_lat) || (stale_done && alu_start);
  assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
  // Non-add ops drive junk carry so masking is observable.
  assign alu_c_out = (alu_sel == 3'd5) ? alu_sum[32] : (alu_a[0] ^ alu_b[31] ^ 1'b1);

  always_comb begin
    alu_result = '0;
    case (alu_sel)
      3'd0: alu_result = alu_a & alu_b;
      3'd1: alu_result = alu_a | alu_b;
      3'd2: alu_result = alu_a ^ alu_b;
      3'd3: alu_result = ~(alu_a | alu_b);
      3'd4: alu_result = {31'd0, alu_a < alu_b};
      3'd5: alu_result = alu_sum[31:0];
      3'd6: alu_result = alu_a - alu_b;
      default: alu_result = (alu_b == 0) ? 32'd0 : alu_a % alu_b;
    endcase
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        err;
    logic        is_mod;
    int          lat;
    int          acc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic        cin;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int last_acc = 0;
  int last_hs = 0;
  int hold_low = 0;
  logic rand_bp = 1'b0;
  int start_cnt = 0;
  logic valid_seen = 1'b0;

  function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] sel, input logic cin,
                                  input int unsigned lat);
    exp_t e;
    logic [63:0] s;
    e.a = a; e.b = b; e.sel = sel; e.cin = cin;
    e.cout = 1'b0; e.err = 1'b0; e.is_mod = (sel == 3'd7); e.lat = 3; e.acc = 0;
    e.res = '0;
    case (sel)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: e.res = a ^ b;
      3'd3: e.res = ~(a | b);
      3'd4: e.res = (a < b) ? 32'd1 : 32'd0;
      3'd5: begin
        s = {32'd0, a} + {32'd0, b} + {63'd0, cin};
        e.res = s[31:0];
        e.cout = s[32];
      end
      3'd6: e.res = a - b;
      default: begin
        if (lat > TO) begin
          e.err = 1'b1; e.res = '0; e.lat = 3 + TO;
        end else begin
          e.res = (b == 0) ? 32'd0 : a % b; e.lat = 3 + int'(lat);
        end
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Response-ready driver and monitor share one block so ready is decided before checking.
  always @(negedge clk) begin
    exp_t e;
    if (hold_low > 0) begin
      rsp_ready = 1'b0;
      if (rsp_valid) hold_low--;
    end else if (rand_bp) begin
      rsp_ready = ($urandom_range(0, 2) != 0);
    end else begin
      rsp_ready = 1'b1;
    end
    if (!reset) begin
      start_cnt = 0;
      valid_seen = 1'b0;
    end else begin
      if (alu_start) start_cnt++;
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
          e = sbq[0];
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_c_out", 64'(rsp_c_out), 64'(e.cout));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("req_ready_busy", 64'(req_ready), 64'd0);
          if (!valid_seen) begin
            valid_seen = 1'b1;
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            chk("start_pulses", 64'(start_cnt), e.is_mod ? 64'd1 : 64'd0);
            chk("alu_a_held", 64'(alu_a), 64'(e.a));
            chk("alu_b_held", 64'(alu_b), 64'(e.b));
            chk("alu_sel_held", 64'(alu_sel), 64'(e.sel));
            chk("alu_cin_held", 64'(alu_cin), 64'(e.cin));
            start_cnt = 0;
          end
          if (rsp_ready) begin
            void'(sbq.pop_front());
            valid_seen = 1'b0;
            last_hs = cyc;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                      input logic cin, input int unsigned lat, input logic stale);
    exp_t e;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel; req_cin = cin;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("accept_wait");
      req_valid = 1'b0;
    end else begin
      mod_lat = lat;
      stale_done = stale;
      e = ref_op(a, b, sel, cin, lat);
      e.acc = cyc;
      last_acc = cyc;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom; req_sel = 3'($urandom); req_cin = 1'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_rsp_c_out_err"}, 64'({rsp_c_out, rsp_err}), 64'd0);
    chk({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
    chk({tag, "_alu_ctl"}, 64'({alu_sel, alu_cin, alu_start}), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rs;
    int          n;
    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_release", 64'(req_ready), 64'd1);

    // Directed cases.
    send(32'h0000_0005, 32'h0000_0003, 3'd5, 1'b1, 1, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 3'd5, 1'b0, 1, 1'b0);
    send(32'd17, 32'd5, 3'd7, 1'b0, 5, 1'b1);
    send(32'd17, 32'd5, 3'd7, 1'b0, TO, 1'b0);
    send(32'd40, 32'd6, 3'd7, 1'b0, 100, 1'b0);
    hold_low = 5;
    send(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 1'b0, 1, 1'b0);
    send(32'd1, 32'd2, 3'd4, 1'b0, 1, 1'b0);
    chk("accept_after_idle", 64'(last_acc), 64'(last_hs + 1));

    // Randomised ops with random response backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rs = 3'($urandom_range(0, 7));
      send(ra, rb, rs, 1'($urandom), $urandom_range(1, 12), 1'($urandom));
    end
    rand_bp = 1'b0;

    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) fail_now("drain_before_reset");

    // Reset in the middle of a mod wait drops the op.
    send(32'd100, 32'd7, 3'd7, 1'b0, 500, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("midop");
    sbq.delete();
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 chk("midop_ready_after_release", 64'(req_ready), 64'd1);
    repeat (14) @(negedge clk);
    chk("midop_no_response", 64'(rsp_valid), 64'd0);

    send(32'd9, 32'd4, 3'd6, 1'b0, 1, 1'b0);
    send(32'd23, 32'd4, 3'd7, 1'b0, 3, 1'b0);

    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) fail_now("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 32-bit ALU port set (a, b, sel, c_in, start, done, result, c_out).
- Accepts one operation at a time over a valid/ready request channel and drives the ALU operand, select, carry-in and start lines.
- Waits a fixed settle cycle for combinational ops, and for done on the multi-cycle mod op.
- Returns result and carry on a valid/ready response channel, with a timeout error flag.

Parameters:
- WIDTH, 32, operand and result width.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for alu_done on a mod op before aborting.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_a  input  WIDTH  operand a.
- req_b  input  WIDTH  operand b.
- req_sel  input  3  op select: 0 and, 1 or, 2 xor, 3 nor, 4 lt, 5 add, 6 sub, 7 mod.
- req_cin  input  1  carry-in for add.
- alu_a  output  WIDTH  registered operand a to ALU.
- alu_b  output  WIDTH  registered operand b to ALU.
- alu_sel  output  3  registered select to ALU.
- alu_cin  output  1  registered carry-in to ALU.
- alu_start  output  1  one-cycle start pulse, mod only.
- alu_result  input  WIDTH  ALU result.
- alu_c_out  input  1  ALU carry-out.
- alu_done  input  1  ALU mod completion.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  WIDTH  captured result.
- rsp_c_out  output  1  captured carry-out; 0 unless sel=5.
- rsp_err  output  1  timeout flag.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - All alu_* outputs, rsp_* outputs and the timeout counter clear to 0.
  - req_ready=0 while reset is asserted; 1 in the first cycle after release.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid&&req_ready, latch req_a, req_b, req_sel, req_cin into alu_a, alu_b, alu_sel, alu_cin.
    - Go to SETTLE if sel!=7, else START.
  - SETTLE:
    - One cycle with operands stable.
    - At the end of the cycle, capture alu_result into rsp_result, and alu_c_out into rsp_c_out if sel=5 (else 0).
    - Set rsp_err=0 and go to RESP.
    - Combinational op latency is 3 cycles from accept to rsp_valid.
  - START:
    - alu_start=1 for exactly this cycle.
    - Clear the counter, go to WAIT.
  - WAIT:
    - alu_start=0; the counter increments each cycle.
    - alu_done is sampled only in WAIT, so a done level left over from a prior op during START is ignored.
    - On alu_done=1: capture alu_result, rsp_c_out=0, rsp_err=0, go to RESP.
    - If the counter reaches TIMEOUT_CYCLES-1 without done: rsp_result=0, rsp_err=1, go to RESP.
    - done and timeout in the same cycle: done wins.
  - RESP:
    - rsp_valid=1; rsp_result, rsp_c_out and rsp_err stay stable until the handshake.
    - On rsp_ready=1: rsp_valid drops next cycle and the state returns to IDLE.
    - req_ready=0, so there is no overlap and at most one op is in flight.
- Operands are held on alu_* from accept until the next accept; they are never changed mid-operation.
- reset asserted mid-operation: immediate return to IDLE with all outputs cleared; the pending op is dropped and produces no response.
- Back-to-back throughput:
  - combinational op: 4 cycles per op with rsp_ready tied high;
  - mod: 4 cycles + done latency.
- Counter width is clog2(TIMEOUT_CYCLES)+1. Arithmetic is unsigned; no width extension of results.

Decomposition:
- Shared package alu_pkg:
  - sel encodings: SEL_AND=0 … SEL_SUB=6, SEL_MOD=7;
  - state enum IDLE/SETTLE/START/WAIT/RESP;
  - default WIDTH.
- One natural sub-module: alu_timeout_counter (clear, enable, expired output). Everything else stays in one FSM module.

Test Plan:
- Add: a=32'h0000_0005, b=32'h0000_0003, sel=5, cin=1, ALU model returns 9 with c_out=0 -> rsp_result=9, rsp_c_out=0, rsp_err=0, rsp_valid exactly 3 cycles after accept, alu_start never asserted.
- Carry: a=32'hFFFF_FFFF, b=1, sel=5, cin=0 -> rsp_result=0, rsp_c_out=1.
- Mod: a=17, b=5, sel=7, model asserts done 10 cycles after start -> one-cycle alu_start, rsp_result=2, rsp_err=0; a stale done high during START is ignored.
- Timeout: sel=7, done never asserted, TIMEOUT_CYCLES=8 -> rsp_valid after 8 WAIT cycles, rsp_result=0, rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after an xor of 32'hF0F0_F0F0 ^ 32'h0FF0_0FF0 -> rsp_result=32'hFF00_FF00 held stable, req_ready=0 throughout, then a new request is accepted the cycle after IDLE is re-entered.
- Reset mid-op: assert reset during WAIT -> all outputs 0 asynchronously, no rsp_valid after release, req_ready=1 on the first post-reset cycle.
